// File: rtl/step_ctrl.sv
// step_ctrl -- pipeline step controller.
//
// Generates the registered clock-enable (o_step) for every pipeline register
// and the PC. It is driven by the debug unit's command interface and supports
// free-run, single-step and counted-burst execution. The pipeline is stopped
// automatically when the halt instruction retires, and the number of enabled
// cycles is counted for readback.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_cmd_valid       command strobe
//   i_cmd[2:0]        NOP/RUN/STEP/BURST/STOP/CLEAR (110/111 act as NOP)
//   i_cmd_arg         BURST step count
//   i_halt            halt instruction in the final stage
//   o_cmd_ready       command accepted when i_cmd_valid & o_cmd_ready
//   o_step            registered pipeline enable
//   o_busy            in RUN, STEP or BURST
//   o_halted          in HALTED
//   o_done            one-cycle pulse when an execution command ends
//   o_cycle_count     number of o_step cycles since reset/CLEAR (wraps)
module step_ctrl #(
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  input  logic [2:0]       i_cmd,
  input  logic [NBITS-1:0] i_cmd_arg,
  input  logic             i_halt,
  output logic             o_cmd_ready,
  output logic             o_step,
  output logic             o_busy,
  output logic             o_halted,
  output logic             o_done,
  output logic [NBITS-1:0] o_cycle_count
);

  localparam logic [2:0] C_RUN   = 3'b001;
  localparam logic [2:0] C_STEP  = 3'b010;
  localparam logic [2:0] C_BURST = 3'b011;
  localparam logic [2:0] C_STOP  = 3'b100;
  localparam logic [2:0] C_CLEAR = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_BURST  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t           r_state, w_nxt_state;
  logic             r_step, r_busy, r_halted, r_done;
  logic [NBITS-1:0] r_cycle, w_nxt_cycle;
  logic [NBITS-1:0] r_burst, w_nxt_burst;
  logic             w_nxt_done;
  logic             w_acc;
  logic             w_halt_hit;
  logic             w_nxt_exec;

  // Ready is a pure state decode, so it is the only output with no register.
  assign o_cmd_ready = (r_state != S_STEP);
  assign w_acc       = i_cmd_valid & o_cmd_ready;
  // Only meaningful in the execution states, where r_step is always high.
  assign w_halt_hit  = i_halt & r_step;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_burst = r_burst;
    w_nxt_done  = 1'b0;
    w_nxt_cycle = r_step ? (r_cycle + NBITS'(1)) : r_cycle;

    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          case (i_cmd)
            C_RUN:   w_nxt_state = S_RUN;
            C_STEP:  w_nxt_state = S_STEP;
            C_BURST: begin
              if (i_cmd_arg != '0) begin
                w_nxt_state = S_BURST;
                w_nxt_burst = i_cmd_arg;
              end else begin
                w_nxt_done = 1'b1;
              end
            end
            C_CLEAR: w_nxt_cycle = '0;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (w_halt_hit) begin
          w_nxt_state = S_HALTED;
          w_nxt_done  = 1'b1;
        end else if (w_acc && i_cmd == C_STOP) begin
          w_nxt_state = S_IDLE;
          w_nxt_done  = 1'b1;
        end
      end
      S_STEP: begin
        w_nxt_state = w_halt_hit ? S_HALTED : S_IDLE;
        w_nxt_done  = 1'b1;
      end
      S_BURST: begin
        // Halt beats STOP, and STOP beats natural completion; any exit
        // discards the remaining count.
        if (w_halt_hit) begin
          w_nxt_state = S_HALTED;
          w_nxt_done  = 1'b1;
          w_nxt_burst = '0;
        end else if (w_acc && i_cmd == C_STOP) begin
          w_nxt_state = S_IDLE;
          w_nxt_done  = 1'b1;
          w_nxt_burst = '0;
        end else begin
          w_nxt_burst = r_burst - NBITS'(1);
          if (r_burst == NBITS'(1)) begin
            w_nxt_state = S_IDLE;
            w_nxt_done  = 1'b1;
          end
        end
      end
      S_HALTED: begin
        if (w_acc && i_cmd == C_CLEAR) begin
          w_nxt_state = S_IDLE;
          w_nxt_cycle = '0;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  assign w_nxt_exec = (w_nxt_state == S_RUN) || (w_nxt_state == S_STEP) ||
                      (w_nxt_state == S_BURST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_step   <= 1'b0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
      r_done   <= 1'b0;
      r_cycle  <= '0;
      r_burst  <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_step   <= w_nxt_exec;
      r_busy   <= w_nxt_exec;
      r_halted <= (w_nxt_state == S_HALTED);
      r_done   <= w_nxt_done;
      r_cycle  <= w_nxt_cycle;
      r_burst  <= w_nxt_burst;
    end
  end

  assign o_step        = r_step;
  assign o_busy        = r_busy;
  assign o_halted      = r_halted;
  assign o_done        = r_done;
  assign o_cycle_count = r_cycle;

endmodule
